mem_arbiter: RTL

//  Sequences the shared single-port 512x32 RAM (addr/data_in/read/write/data_out) between two requesters:

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) sequencer for a shared single-port RAM with a fixed strobe hold time.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking instead of data-over-fetch priority.
module mem_arbiter #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_gnt_d, w_gnt_d;
    logic                r_we, w_we;
    logic                r_oor, w_oor;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic [DATA_W-1:0]   r_f_rdata, w_f_rdata;
    logic [DATA_W-1:0]   r_d_rdata, w_d_rdata;
    logic                r_f_ack, w_f_ack;
    logic                r_d_ack, w_d_ack;
    logic                r_err, w_err;
    logic                r_busy, w_busy;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr;
    logic [DATA_W-1:0]   r_ram_din, w_ram_din;
    logic                r_ram_read, w_ram_read;
    logic                r_ram_write, w_ram_write;
    logic                w_pick_d;

`ifdef MEM_ARB_RR_EN
    logic                r_last_d, w_last_d;

    // On a tie, grant whichever requester was not granted last.
    assign w_pick_d = d_req & (~f_req | ~r_last_d);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_last_d <= 1'b1;
        else      r_last_d <= w_last_d;
    end
`else
    assign w_pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_gnt_d     <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
            r_f_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_gnt_d     <= w_gnt_d;
            r_we        <= w_we;
            r_oor       <= w_oor;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_f_rdata   <= w_f_rdata;
            r_d_rdata   <= w_d_rdata;
            r_f_ack     <= w_f_ack;
            r_d_ack     <= w_d_ack;
            r_err       <= w_err;
            r_busy      <= w_busy;
            r_ram_addr  <= w_ram_addr;
            r_ram_din   <= w_ram_din;
            r_ram_read  <= w_ram_read;
            r_ram_write <= w_ram_write;
        end
    end

    // Next state plus next value of every registered output, so strobes line up with ACCESS.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_gnt_d     = r_gnt_d;
        w_we        = r_we;
        w_oor       = r_oor;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_f_rdata   = r_f_rdata;
        w_d_rdata   = r_d_rdata;
        w_f_ack     = 1'b0;
        w_d_ack     = 1'b0;
        w_err       = 1'b0;
        w_ram_addr  = '0;
        w_ram_din   = '0;
        w_ram_read  = 1'b0;
        w_ram_write = 1'b0;
`ifdef MEM_ARB_RR_EN
        w_last_d    = r_last_d;
`endif
        case (r_state)
            S_IDLE: begin
                if (f_req || d_req) begin
                    w_gnt_d     = w_pick_d;
                    w_addr      = w_pick_d ? d_addr : f_addr;
                    w_wdata     = w_pick_d ? d_wdata : '0;
                    w_we        = w_pick_d & d_we;
                    w_oor       = (w_addr >= ADDR_W'(DEPTH));
                    w_cnt       = CNT_W'(WAIT_CYCLES);
                    w_state     = S_ACCESS;
                    w_ram_addr  = w_addr;
                    w_ram_din   = w_wdata;
                    w_ram_read  = ~w_we & ~w_oor;
                    w_ram_write = w_we & ~w_oor;
`ifdef MEM_ARB_RR_EN
                    w_last_d    = w_pick_d;
`endif
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    if (!r_we) begin
                        if (r_gnt_d) w_d_rdata = r_oor ? '0 : ram_dout;
                        else         w_f_rdata = r_oor ? '0 : ram_dout;
                    end
                    w_d_ack = r_gnt_d;
                    w_f_ack = ~r_gnt_d;
                    w_err   = r_oor;
                    w_state = S_ACK;
                end else begin
                    w_cnt       = r_cnt - CNT_W'(1);
                    w_ram_addr  = r_addr;
                    w_ram_din   = r_wdata;
                    w_ram_read  = ~r_we & ~r_oor;
                    w_ram_write = r_we & ~r_oor;
                end
            end
            S_ACK:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    assign f_ack     = r_f_ack;
    assign f_rdata   = r_f_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    assign busy      = r_busy;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign ram_read  = r_ram_read;
    assign ram_write = r_ram_write;

endmodule
